// File: rtl/sd_cmd_pkg.sv
// Shared types and frame geometry for the SD host command path
// (response checker and command serializer).
package sd_cmd_pkg;

    typedef enum logic [1:0] {
        RSP_R1   = 2'd0,
        RSP_R3   = 2'd1,
        RSP_R2   = 2'd2,
        RSP_RSVD = 2'd3
    } rsp_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int RSP_SHORT_BITS = 48;
    localparam int RSP_LONG_BITS  = 136;

    localparam logic [6:0] CRC7_POLY    = 7'h09;
    localparam logic [5:0] IDX_ALL_ONES = 6'h3F;

    localparam int BIT_START   = 0;
    localparam int BIT_TRANS   = 1;
    localparam int IDX_LO      = 2;
    localparam int IDX_HI      = 7;
    localparam int ARG_LO      = 8;
    localparam int ARG_HI      = 39;
    localparam int SCRC_LO     = 40;
    localparam int SCRC_HI     = 46;
    localparam int LPAY_LO     = 8;
    localparam int LCRC_COV_HI = 127;
    localparam int LCRC_LO     = 128;
    localparam int LCRC_HI     = 134;

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1, init 0); clear has priority over shift.
module crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;

    assign fb = crc[6] ^ bit_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (shift_en) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/cmd_response_checker.sv
// Walks a captured SD command response one bit per clock and checks framing, index and CRC7.
// Optional CMD_RSP_ERR_CNT_EN adds err_cnt_clr / err_cnt (saturating count of errored frames).
//
// state | meaning
// IDLE  | waiting for a rising frame_valid
// WALK  | processing frame bit [counter] each clock
// DONE  | result presented on rsp_*, waiting for rsp_ack
module cmd_response_checker
    import sd_cmd_pkg::*;
#(
    parameter int FRAME_BITS   = 136,
    parameter int BITS_COUNTER = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  frame_valid,
    input  logic [1:0]            rsp_type,
    input  logic [5:0]            expect_index,
    output logic                  rsp_valid,
    input  logic                  rsp_ack,
    output logic [5:0]            rsp_index,
    output logic [127:0]          rsp_payload,
    output logic                  err_start,
    output logic                  err_trans,
    output logic                  err_index,
    output logic                  err_crc,
    output logic                  err_end,
    output logic                  rsp_ok
`ifdef CMD_RSP_ERR_CNT_EN
    ,
    input  logic                  err_cnt_clr,
    output logic [7:0]            err_cnt
`endif
);

    chk_state_e              state, state_n;
    logic                    fv_q;
    logic [FRAME_BITS-1:0]   frame_l;
    rsp_type_e               type_l;
    logic [BITS_COUNTER-1:0] cnt;
    logic [5:0]              idx_r;
    logic [127:0]            pay_r;
    logic [6:0]              rx_crc;
    logic [6:0]              crc;
    logic                    e_start, e_trans, e_index, e_crc, e_end;

    logic       capture, walk, last, cur_bit, is_long;
    logic       crc_shift, pay_shift, rx_shift;
    logic       fin_err_index, fin_err_crc, fin_err_end;
    logic [5:0] exp_idx;
    int         pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            fv_q  <= 1'b1;
        end else begin
            state <= state_n;
            fv_q  <= frame_valid;
        end
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        walk    = 1'b0;
        case (state)
            IDLE: if (frame_valid && !fv_q) begin
                capture = 1'b1;
                state_n = WALK;
            end
            WALK: begin
                walk = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: if (rsp_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Field decode for the bit currently under the walk pointer.
    always_comb begin
        is_long       = (type_l == RSP_R2);
        pos           = int'(cnt);
        cur_bit       = frame_l[cnt];
        last          = is_long ? (pos == RSP_LONG_BITS - 1) : (pos == RSP_SHORT_BITS - 1);
        crc_shift     = walk && (is_long ? (pos >= LPAY_LO && pos <= LCRC_COV_HI) : (pos <= ARG_HI));
        pay_shift     = is_long ? (pos >= LPAY_LO) : (pos >= ARG_LO && pos <= ARG_HI);
        rx_shift      = is_long ? (pos >= LCRC_LO && pos <= LCRC_HI) : (pos >= SCRC_LO && pos <= SCRC_HI);
        exp_idx       = (type_l == RSP_R1) ? expect_index : IDX_ALL_ONES;
        fin_err_index = (idx_r != exp_idx);
        fin_err_crc   = (type_l != RSP_R3) && (rx_crc != crc);
        fin_err_end   = ~cur_bit;
    end

    crc7_serial u_crc (
        .clk      (clk),
        .reset    (reset),
        .clear    (capture),
        .shift_en (crc_shift),
        .bit_in   (cur_bit),
        .crc      (crc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_l <= '0;
            type_l  <= RSP_R1;
            cnt     <= '0;
            idx_r   <= '0;
            pay_r   <= '0;
            rx_crc  <= '0;
            e_start <= 1'b0;
            e_trans <= 1'b0;
            e_index <= 1'b0;
            e_crc   <= 1'b0;
            e_end   <= 1'b0;
        end else if (capture) begin
            frame_l <= frame;
            type_l  <= (rsp_type == 2'd3) ? RSP_R1 : rsp_type_e'(rsp_type);
            cnt     <= '0;
            idx_r   <= '0;
            pay_r   <= '0;
            rx_crc  <= '0;
            e_start <= 1'b0;
            e_trans <= 1'b0;
            e_index <= 1'b0;
            e_crc   <= 1'b0;
            e_end   <= 1'b0;
        end else if (walk) begin
            if (!last) cnt <= cnt + BITS_COUNTER'(1);
            if (pos == BIT_START) e_start <= cur_bit;
            if (pos == BIT_TRANS) e_trans <= cur_bit;
            if (pos >= IDX_LO && pos <= IDX_HI) idx_r <= {idx_r[4:0], cur_bit};
            if (pay_shift) pay_r <= {pay_r[126:0], cur_bit};
            if (rx_shift) rx_crc <= {rx_crc[5:0], cur_bit};
            if (last) begin
                e_index <= fin_err_index;
                e_crc   <= fin_err_crc;
                e_end   <= fin_err_end;
            end
        end
    end

    assign rsp_valid   = (state == DONE);
    assign rsp_index   = idx_r;
    assign rsp_payload = pay_r;
    assign err_start   = e_start;
    assign err_trans   = e_trans;
    assign err_index   = e_index;
    assign err_crc     = e_crc;
    assign err_end     = e_end;
    assign rsp_ok      = rsp_valid && !(e_start || e_trans || e_index || e_crc || e_end);

`ifdef CMD_RSP_ERR_CNT_EN
    logic [7:0] err_cnt_r;
    logic       any_err;

    assign any_err = e_start || e_trans || fin_err_index || fin_err_crc || fin_err_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_r <= '0;
        end else if (err_cnt_clr) begin
            err_cnt_r <= '0;
        end else if (walk && last && any_err && err_cnt_r != 8'hFF) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_cmd_response_checker.sv
// Scoreboard bench for cmd_response_checker: the driver queues expected results,
// a monitor compares and acknowledges whenever rsp_valid is presented.
module tb_cmd_response_checker;

    logic         clk = 1'b0;
    logic         reset;
    logic [135:0] frame;
    logic         frame_valid;
    logic [1:0]   rsp_type;
    logic [5:0]   expect_index;
    logic         rsp_valid;
    logic         rsp_ack;
    logic [5:0]   rsp_index;
    logic [127:0] rsp_payload;
    logic         err_start, err_trans, err_index, err_crc, err_end, rsp_ok;
`ifdef CMD_RSP_ERR_CNT_EN
    logic         err_cnt_clr;
    logic [7:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [5:0]   idx;
        logic [127:0] pay;
        logic [4:0]   errs;
        int           n;
        int           c0;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_response_checker dut (
        .clk          (clk),
        .reset        (reset),
        .frame        (frame),
        .frame_valid  (frame_valid),
        .rsp_type     (rsp_type),
        .expect_index (expect_index),
        .rsp_valid    (rsp_valid),
        .rsp_ack      (rsp_ack),
        .rsp_index    (rsp_index),
        .rsp_payload  (rsp_payload),
        .err_start    (err_start),
        .err_trans    (err_trans),
        .err_index    (err_index),
        .err_crc      (err_crc),
        .err_end      (err_end),
        .rsp_ok       (rsp_ok)
`ifdef CMD_RSP_ERR_CNT_EN
        ,
        .err_cnt_clr  (err_cnt_clr),
        .err_cnt      (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] f, input int lo, input int hi);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = lo; i <= hi; i++) begin
            fb = f[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [135:0] build_short(input logic [5:0] idx, input logic [31:0] arg, input bit r3);
        logic [135:0] f;
        logic [6:0]   c;
        f = '0;
        for (int i = 0; i < 6; i++) f[2+i] = idx[5-i];
        for (int i = 0; i < 32; i++) f[8+i] = arg[31-i];
        c = crc7(f, 0, 39);
        for (int i = 0; i < 7; i++) f[40+i] = r3 ? 1'b1 : c[6-i];
        f[47] = 1'b1;
        return f;
    endfunction

    function automatic logic [135:0] build_long(input logic [119:0] hi);
        logic [135:0] f;
        logic [6:0]   c;
        f = '0;
        for (int i = 0; i < 6; i++) f[2+i] = 1'b1;
        for (int i = 0; i < 120; i++) f[8+i] = hi[119-i];
        c = crc7(f, 8, 127);
        for (int i = 0; i < 7; i++) f[128+i] = c[6-i];
        f[135] = 1'b1;
        return f;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, {rsp_valid, rsp_ok, err_start, err_trans, err_index, err_crc, err_end, rsp_index}, '0);
        chk({tag, "_payload"}, rsp_payload, '0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual=%0d_pending required=0", q.size());
        end
    endtask

    task automatic send(input logic [135:0] f, input logic [1:0] t, input logic [5:0] ein,
                        input logic [5:0] xidx, input logic [127:0] xpay, input logic [4:0] xerr,
                        input bit hold);
        exp_t e;
        wait_idle();
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        frame        = f;
        rsp_type     = t;
        expect_index = ein;
        frame_valid  = 1'b1;
        @(posedge clk);
        #1;
        e.idx  = xidx;
        e.pay  = xpay;
        e.errs = xerr;
        e.n    = (t == 2'd2) ? 136 : 48;
        e.c0   = cyc;
        q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            frame_valid = 1'b0;
        end
    endtask

    // Monitor: compare on first sight of rsp_valid, check hold, then acknowledge.
    initial begin
        exp_t e;
        rsp_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=valid_idx_%0h required=idle", rsp_index);
                end else begin
                    e = q[0];
                    chk("latency", cyc - e.c0, e.n);
                    chk("index", rsp_index, e.idx);
                    chk("payload", rsp_payload, e.pay);
                    chk("err_flags", {err_start, err_trans, err_index, err_crc, err_end}, e.errs);
                    chk("rsp_ok", rsp_ok, e.errs == 5'b0);
                end
                repeat (2) @(negedge clk);
                if (q.size() != 0)
                    chk("held", {rsp_valid, rsp_index, err_start, err_trans, err_index, err_crc, err_end},
                        {1'b1, e.idx, e.errs});
                rsp_ack = 1'b1;
                @(negedge clk);
                rsp_ack = 1'b0;
                if (q.size() != 0) begin
                    chk("after_ack", {rsp_valid, rsp_index, rsp_payload[31:0]}, {1'b0, e.idx, e.pay[31:0]});
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [135:0] f, fx, lf, bad;
        logic [119:0] cid;
        logic [6:0]   lc;

        reset        = 1'b0;
        frame        = '0;
        frame_valid  = 1'b0;
        rsp_type     = 2'd0;
        expect_index = 6'd0;
`ifdef CMD_RSP_ERR_CNT_EN
        err_cnt_clr  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        f = build_short(6'd17, 32'h0000_0900, 1'b0);
        send(f, 2'd0, 6'd17, 6'd17, {96'b0, 32'h0000_0900}, 5'b00000, 1'b0);

        fx = f;
        fx[30] = ~fx[30];
        send(fx, 2'd0, 6'd17, 6'd17, {96'b0, 32'h0000_0B00}, 5'b00010, 1'b0);

        send(build_short(6'd18, 32'h0000_0900, 1'b0), 2'd0, 6'd17, 6'd18, {96'b0, 32'h0000_0900}, 5'b00100, 1'b0);

        send(build_short(6'h3F, 32'h80FF_8000, 1'b1), 2'd1, 6'd17, 6'h3F, {96'b0, 32'h80FF_8000}, 5'b00000, 1'b0);

        send(build_short(6'h01, 32'h0000_1234, 1'b1), 2'd1, 6'h01, 6'h01, {96'b0, 32'h0000_1234}, 5'b00100, 1'b0);

        cid = 120'h03534453443038301012345678014C;
        lf  = build_long(cid);
        lc  = crc7(lf, 8, 127);
        send(lf, 2'd2, 6'd0, 6'h3F, {cid, lc, 1'b1}, 5'b00000, 1'b0);

        fx = lf;
        fx[135] = 1'b0;
        send(fx, 2'd2, 6'd0, 6'h3F, {cid, lc, 1'b0}, 5'b00001, 1'b0);

        send(f, 2'd3, 6'd17, 6'd17, {96'b0, 32'h0000_0900}, 5'b00000, 1'b0);

        fx = f;
        fx[0] = 1'b1;
        send(fx, 2'd0, 6'd17, 6'd17, {96'b0, 32'h0000_0900}, 5'b10010, 1'b0);

        fx = f;
        fx[1] = 1'b1;
        send(fx, 2'd0, 6'd17, 6'd17, {96'b0, 32'h0000_0900}, 5'b01010, 1'b0);

        // frame_valid stays high across the ack: no second capture allowed.
        send(f, 2'd0, 6'd17, 6'd17, {96'b0, 32'h0000_0900}, 5'b00000, 1'b1);
        wait_idle();
        repeat (60) @(negedge clk);
        chk("no_recapture_after_ack", rsp_valid, 1'b0);

        // Start a walk, then reset mid-frame with frame_valid still high.
        frame_valid = 1'b0;
        @(negedge clk);
        frame_valid = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("reset_mid_walk");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("after_reset_release");
        repeat (60) @(negedge clk);
        chk("no_capture_after_reset", rsp_valid, 1'b0);

        send(build_short(6'd5, 32'hDEAD_BEEF, 1'b0), 2'd0, 6'd5, 6'd5, {96'b0, 32'hDEAD_BEEF}, 5'b00000, 1'b0);
        wait_idle();

`ifdef CMD_RSP_ERR_CNT_EN
        @(negedge clk);
        err_cnt_clr = 1'b1;
        @(negedge clk);
        err_cnt_clr = 1'b0;
        chk("err_cnt_cleared", err_cnt, 8'd0);
        bad = build_short(6'd17, 32'h0000_0900, 1'b0);
        bad[47] = 1'b0;
        for (int k = 0; k < 300; k++)
            send(bad, 2'd0, 6'd17, 6'd17, {96'b0, 32'h0000_0900}, 5'b00001, 1'b0);
        wait_idle();
        chk("err_cnt_saturated", err_cnt, 8'd255);
        send(bad, 2'd0, 6'd17, 6'd17, {96'b0, 32'h0000_0900}, 5'b00001, 1'b1);
        repeat (47) @(posedge clk);
        @(negedge clk);
        err_cnt_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_cnt_clr = 1'b0;
        chk("err_cnt_clr_wins", err_cnt, 8'd0);
        wait_idle();
`else
        bad = '0;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
